// File: rtl/line_fetch_memory.sv
// rtl/line_fetch_memory.sv - read-only line memory with configurable fetch latency
// Optional last-line buffer enabled by defining IMEM_LINE_BUFFER_EN.
module line_fetch_memory #(
    parameter int ADDR_W      = 32,
    parameter int LINE_BYTES  = 16,
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    busy,
    output logic                    resp_valid,
    output logic [ADDR_W-1:0]       resp_addr,
    output logic [8*LINE_BYTES-1:0] data_line
);

    localparam int         OFF_W     = $clog2(LINE_BYTES);
    localparam logic [3:0] RELOAD    = 4'(LATENCY - 1);
    localparam logic [7:0] BASE_MASK = (DEPTH_BYTES >= 256) ? 8'hFF : 8'(DEPTH_BYTES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state, state_next;
    logic [3:0]              cnt, cnt_next;
    logic [ADDR_W-1:0]       line_addr, line_next, req_line;
    logic                    load, load_from_req, buf_hit;
    logic [7:0]              base;
    logic [8*LINE_BYTES-1:0] rom_line;
    logic                    unused_offset;

    assign req_line      = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign unused_offset = ^req_addr[OFF_W-1:0];

`ifdef IMEM_LINE_BUFFER_EN
    logic buf_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            buf_valid <= 1'b0;
        else if (load)
            buf_valid <= 1'b1;
    end

    // resp_addr/data_line already hold the buffered line, so a hit needs no reload
    assign buf_hit = buf_valid && (req_line == resp_addr);
`else
    assign buf_hit = 1'b0;
`endif

    // Program image: byte i holds i mod 256, so only the low index byte matters
    assign base = (load_from_req ? req_line[7:0] : line_addr[7:0]) & BASE_MASK;

    always_comb begin
        rom_line = '0;
        for (int k = 0; k < LINE_BYTES; k++)
            rom_line[8*k +: 8] = base + 8'(k);
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        line_next     = line_addr;
        load          = 1'b0;
        load_from_req = 1'b0;
        case (state)
            IDLE, RESP: begin
                state_next = IDLE;
                if (req_valid) begin
                    line_next = req_line;
                    if (buf_hit) begin
                        state_next = RESP;
                    end else if (LATENCY == 1) begin
                        state_next    = RESP;
                        load          = 1'b1;
                        load_from_req = 1'b1;
                        cnt_next      = 4'd0;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = RELOAD;
                    end
                end
            end
            WAIT: begin
                if (req_valid && (req_line != line_addr)) begin
                    line_next = req_line;
                    cnt_next  = RELOAD;
                end else if (cnt <= 4'd1) begin
                    state_next = RESP;
                    load       = 1'b1;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            line_addr <= '0;
            resp_addr <= '0;
            data_line <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            line_addr <= line_next;
            if (load) begin
                resp_addr <= load_from_req ? req_line : line_addr;
                data_line <= rom_line;
            end
        end
    end

    assign busy       = (state == WAIT);
    assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_line_fetch_memory.sv
// tb/tb_line_fetch_memory.sv - scoreboard bench for line_fetch_memory
module tb_line_fetch_memory;

    localparam int LAT = 4;
`ifdef IMEM_LINE_BUFFER_EN
    localparam int   HIT_LAT  = 1;
    localparam logic HIT_BUSY = 1'b0;
`else
    localparam int   HIT_LAT  = LAT;
    localparam logic HIT_BUSY = 1'b1;
`endif

    localparam logic [127:0] D00 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] D20 = 128'h2F2E2D2C2B2A29282726252423222120;
    localparam logic [127:0] D30 = 128'h3F3E3D3C3B3A39383736353433323130;
    localparam logic [127:0] D40 = 128'h4F4E4D4C4B4A49484746454443424140;
    localparam logic [127:0] D50 = 128'h5F5E5D5C5B5A59585756555453525150;
    localparam logic [127:0] D80 = 128'h8F8E8D8C8B8A89888786858483828180;
    localparam logic [127:0] D90 = 128'h9F9E9D9C9B9A99989796959493929190;
    localparam logic [127:0] DB0 = 128'hBFBEBDBCBBBAB9B8B7B6B5B4B3B2B1B0;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         busy;
    logic         resp_valid;
    logic [31:0]  resp_addr;
    logic [127:0] data_line;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
        int           at;
    } exp_t;
    exp_t sbq[$];

    line_fetch_memory #(
        .ADDR_W(32), .LINE_BYTES(16), .DEPTH_BYTES(1024), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .busy(busy), .resp_valid(resp_valid), .resp_addr(resp_addr), .data_line(data_line)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got response for %h at cycle %0d, required none", resp_addr, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("resp_addr", 128'(resp_addr), 128'(e.addr));
                check("data_line", data_line, e.data);
                check("resp_cycle", 128'(cyc), 128'(e.at));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] ea,
                         input logic [127:0] ed, input int lat);
        req_valid = 1'b1;
        req_addr  = addr;
        sbq.push_back('{addr: ea, data: ed, at: cyc + lat});
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_resp_valid", 128'(resp_valid), 128'd0);
        check("rst_resp_addr", 128'(resp_addr), 128'd0);
        check("rst_data_line", data_line, 128'd0);

        fetch(32'h00, 32'h00, D00, LAT);
        check("busy_after_accept", 128'(busy), 128'd1);
        repeat (5) step();

        fetch(32'h23, 32'h20, D20, LAT);
        repeat (5) step();

        fetch(32'h10, 32'h10, '0, 0);
        void'(sbq.pop_back());
        check("restart_busy0", 128'(busy), 128'd1);
        step();
        check("restart_busy1", 128'(busy), 128'd1);
        fetch(32'h40, 32'h40, D40, LAT);
        for (int i = 0; i < 3; i++) begin
            check("restart_busy_hold", 128'(busy), 128'd1);
            step();
        end
        check("restart_busy_drop", 128'(busy), 128'd0);
        repeat (3) step();

        fetch(32'h400, 32'h400, D00, LAT);
        repeat (5) step();

        req_valid = 1'b1;
        req_addr  = 32'h80;
        sbq.push_back('{addr: 32'h80, data: D80, at: cyc + LAT});
        repeat (LAT) step();
        check("b2b_resp_valid", 128'(resp_valid), 128'd1);
        req_addr = 32'h90;
        sbq.push_back('{addr: 32'h90, data: D90, at: cyc + LAT});
        step();
        check("b2b_no_idle_busy", 128'(busy), 128'd1);
        repeat (LAT - 1) step();
        req_valid = 1'b0;
        repeat (3) step();

        req_valid = 1'b1;
        req_addr  = 32'hA0;
        step();
        req_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_resp_valid", 128'(resp_valid), 128'd0);
        check("midrst_resp_addr", 128'(resp_addr), 128'd0);
        check("midrst_data_line", data_line, 128'd0);
        step();
        rst = 1'b0;
        step();
        check("postrst_busy", 128'(busy), 128'd0);
        repeat (6) step();
        fetch(32'hB0, 32'hB0, DB0, LAT);
        repeat (5) step();

        fetch(32'h30, 32'h30, D30, LAT);
        repeat (5) step();
        fetch(32'h34, 32'h30, D30, HIT_LAT);
        check("hit_busy", 128'(busy), 128'(HIT_BUSY));
        repeat (5) step();
        fetch(32'h50, 32'h50, D50, LAT);
        check("miss_busy", 128'(busy), 128'd1);

        repeat (10) step();
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL missing_resp: got %0d responses outstanding, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/line_fetch_memory.md
# line_fetch_memory

Parametrised read-only instruction memory that returns one aligned multi-byte line per request after a configurable access latency, modelling slow backing memory behind the instruction cache. Sits between the cache refill logic and the program image. Adds an explicit request/response handshake, in-flight restart on a new line address, and an optional last-line buffer.

## Interface
- ADDR_W, 32: request address width in bits.
- LINE_BYTES, 16: bytes per line; power of two, ≥ 4.
- DEPTH_BYTES, 1024: memory size in bytes; power of two, ≥ LINE_BYTES.
- LATENCY, 4: rising edges from accept to response; range 1..15.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request strobe, sampled on each rising edge.
- req_addr  in  ADDR_W  byte address; the low log2(LINE_BYTES) bits are ignored.
- busy  out  1  high while a fetch is in flight (state WAIT).
- resp_valid  out  1  one-cycle pulse; data_line and resp_addr are valid.
- resp_addr  out  ADDR_W  line-aligned address of the returned line.
- data_line  out  8*LINE_BYTES  line data; byte k is at bits [8k+7:8k], little-endian.

## Operation
- Storage: byte array of DEPTH_BYTES. The initial image sets byte i to i mod 256. The memory has no write port.
- Line address: {req_addr[ADDR_W-1:log2(LINE_BYTES)], zeros}. The array index is the line address mod DEPTH_BYTES, so out-of-range addresses wrap.
- States: IDLE, WAIT, RESP.
- IDLE with req_valid: latch the line address, load the counter with LATENCY-1, go to WAIT (or to RESP directly if LATENCY=1).
- WAIT:
  - req_valid with the same line: ignored; the countdown continues.
  - req_valid with a different line: restart. Latch the new line, reload the counter to LATENCY-1, stay in WAIT. The old fetch never responds.
  - Otherwise, when the counter reaches 0: load data_line and resp_addr, go to RESP.
- RESP: resp_valid is high for this one cycle.
  - req_valid here is accepted exactly as in IDLE (back-to-back fetches allowed).
  - Otherwise go to IDLE.
- data_line and resp_addr hold their last values until the next response.
- busy = (state == WAIT).

## Timing
- Reset values: state IDLE, counter 0, busy 0, resp_valid 0, resp_addr 0, data_line 0. Memory contents are not affected by reset.
- Reset asserted mid-fetch aborts the fetch; no response follows after reset is released.
- Accept at edge T: resp_valid is high during the cycle after edge T+LATENCY-1 (LATENCY edges counted including T).
- A restart at edge R discards prior progress; the response follows edge R+LATENCY-1.
- Throughput is one line per LATENCY cycles. With back-to-back requests issued in RESP there are no idle cycles.
- req_valid held high on a constant address produces repeated fetches: one response every LATENCY cycles.

## Configuration
- IMEM_LINE_BUFFER_EN defined:
  - Adds a buffer for the last returned line, with a valid bit cleared by rst.
  - An accepted request whose line equals the buffered resp_addr goes straight to RESP. The response comes the next cycle regardless of LATENCY, and busy never rises.
  - A same-line request during WAIT is still ignored.
- IMEM_LINE_BUFFER_EN undefined: every request pays the full LATENCY.

## Test plan
- Reset, then req_valid for one cycle at address 0x00, LATENCY=4 -> resp_valid pulses once, 4 edges after accept; data_line = 0x0F0E...0100; resp_addr = 0.
- Request at 0x23 -> resp_addr = 0x20; data_line byte0 = 0x20, byte15 = 0x2F.
- Request at 0x10, then 0x40 two cycles later -> single response, for 0x40 only, LATENCY edges after the second accept; busy stays high throughout.
- Request at 0x400 with DEPTH_BYTES=1024 -> wraps to index 0; data_line equals the line at 0x00; resp_addr = 0x400.
- rst pulsed during WAIT -> resp_valid stays 0 and all outputs read 0; a new request afterwards completes normally.
- With IMEM_LINE_BUFFER_EN: fetch 0x30, then request 0x30 again -> second resp_valid comes 1 edge after accept, with busy low. A request to 0x50 -> full LATENCY.
